frame_accumulator: RTL and testbench
====================================

# frame_accumulator

Per-chain, element-wise frame reducer directly downstream of the input buffer. Consumes the buffer's `vector_out`, `valid_out`, `bof_out`, `eof_out` and `chainId_out` stream, and applies one firmware-selected operation per chain: pass, sum, max or min. Reducing chains produce one vector per frame; pass chains forward every vector. The output feeds the rest of the trace pipeline.

## Interface
- `N`, default 8: lanes per vector.
- `DATA_WIDTH`, default 32: bits per lane, two's complement.
- `MAX_CHAINS`, default 4: number of chains; must equal 4 so that 4 × 2-bit ops fill one config byte.
- `CONFIG_ID`, default 2: `configId` value addressed to this block.
- `INITIAL_FIRMWARE`, default 0: reset value of the op register.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `tracing` input 1: high while tracing; config writes are ignored while high.
- `configId` input 8: config address.
- `configData` input 8: config payload.
- `valid_in` input 1: input vector valid.
- `bof_in` input 1: first vector of a frame.
- `eof_in` input 1: last vector of a frame.
- `chainId_in` input $clog2(MAX_CHAINS): chain tag.
- `vector_in` input [DATA_WIDTH-1:0] × N: input lanes.
- `valid_out` output 1: output vector valid.
- `bof_out` output 1: first vector of an output frame.
- `eof_out` output 1: last vector of an output frame.
- `chainId_out` output $clog2(MAX_CHAINS): chain tag of the output.
- `vector_out` output [DATA_WIDTH-1:0] × N: result lanes.

## Operation
- **Op register** (8 bits): bits [2c+1:2c] select the op for chain c.
  - Encoding: 0 = PASS, 1 = SUM, 2 = MAX, 3 = MIN.
  - Loaded from `configData` on a cycle where `configId==CONFIG_ID` and `tracing==0`.
  - A config write does not clear accumulators.
- **Per-chain state**: one accumulator (N lanes) plus a state bit, IDLE or ACCUM. Only the chain named by `chainId_in` is touched in a cycle.
- **PASS chain**: input vector, bof, eof and chainId are registered straight to the outputs with `valid_out=1`. Chain state is untouched.
- **Reducing chain, `valid_in=1`**:
  - Start condition: `bof_in=1`, or the chain is IDLE. Then acc ← `vector_in`.
  - Otherwise: acc ← op(acc, `vector_in`), lane-wise.
  - If `eof_in=0`: state → ACCUM, `valid_out=0`.
  - If `eof_in=1`:
    - `vector_out` ← the updated acc value. This is the same value written to acc, i.e. `vector_in` when the start condition held.
    - `valid_out=1`, `bof_out=1`, `eof_out=1`.
    - State → IDLE.
- **Arithmetic**: SUM wraps modulo 2^DATA_WIDTH with no saturation. MAX and MIN are signed compares.
- **Frame interleaving**: frames on different chains may interleave cycle by cycle. Accumulators are fully independent.
- **`valid_in=0`**: no state change; `valid_out=0`. `vector_out` holds its last value.
- **Mid-frame op change**: the new op applies from the next accepted vector.

## Timing
- Latency: 1 cycle from input valid to output valid. Fully pipelined, one vector accepted per cycle, no backpressure.
- Reset (`rst_n=0`, asynchronous):
  - Outputs: `valid_out`, `bof_out`, `eof_out`, `chainId_out` = 0; `vector_out` all lanes 0.
  - Internal: accumulators 0, all chains IDLE, op register = INITIAL_FIRMWARE.
- Reset asserted mid-frame discards the partial frame. The first vector after reset starts a new frame even without `bof_in`.
- `bof_in` and `eof_in` in the same cycle: single-vector frame; output equals the input.
- `bof_in` arriving while in ACCUM: the open frame is silently dropped and a new one starts.
- A config write coinciding with a valid input: the input uses the old op; the new op takes effect next cycle.

## Structure
- **Package `frame_acc_pkg`**: op enum `acc_op_t` (PASS, SUM, MAX, MIN), the 2-bit op field width, and the state enum (IDLE, ACCUM).
- **Sub-module `frame_acc_lane`**: combinational single-lane reduce of two DATA_WIDTH values under an `acc_op_t`, instantiated N times.
- Accumulators are registers, not RAM, to keep the 1-cycle latency.

## Test plan
1. **PASS chain**: op=0x00; drive chain 0 with lanes = 5, bof=1, eof=0 → next cycle `valid_out=1`, lanes = 5, bof_out=1, eof_out=0, `chainId_out=0`.
2. **SUM on chain 1**: op=0x04; three vectors of lanes = 3 (bof on the first, eof on the last) → single output with lanes = 9, bof_out=eof_out=1, `chainId_out=1`, no valid on the first two.
3. **Signed MAX/MIN, interleaved**: op=0x38 (chain 1 MAX, chain 2 MIN); interleave chain 1 [-4, 7] with chain 2 [-4, 7] → chain 1 outputs 7, chain 2 outputs -4.
4. **SUM wrap**: DATA_WIDTH=32, 0xFFFFFFFF + 0x00000002 → 0x00000001.
5. **Async reset mid-frame**: assert `rst_n` low after 2 accumulated vectors → outputs 0 immediately; next frame (lanes = 1 then 2, eof on the second) outputs 3, not a stale sum.
6. **Config gating**: `tracing=1` with `configId=CONFIG_ID`, `configData=0xFF` → op register unchanged. Same write with `tracing=0` → all chains MIN from the next cycle.

Source files
------------

// File: rtl/frame_acc_pkg.sv
// Shared types for the per-chain frame accumulator: reduce ops and chain state.
package frame_acc_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_PASS = 2'd0,
    OP_SUM  = 2'd1,
    OP_MAX  = 2'd2,
    OP_MIN  = 2'd3
  } acc_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } chain_state_t;

endpackage

// File: rtl/frame_acc_lane.sv
// Combinational single-lane reduce: combines the accumulator lane with an incoming lane.
import frame_acc_pkg::*;

module frame_acc_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  acc_op_t               op_i,
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  // Lane-wise reduce; SUM wraps, MAX/MIN compare as two's complement.
  always_comb begin
    result_o = din_i;
    case (op_i)
      OP_SUM:  result_o = acc_i + din_i;
      OP_MAX:  result_o = ($signed(acc_i) > $signed(din_i)) ? acc_i : din_i;
      OP_MIN:  result_o = ($signed(acc_i) < $signed(din_i)) ? acc_i : din_i;
      OP_PASS: result_o = din_i;
      default: result_o = din_i;
    endcase
  end

endmodule

// File: rtl/frame_accumulator.sv
// Per-chain element-wise frame reducer (pass/sum/max/min) with one-cycle latency.
import frame_acc_pkg::*;

module frame_accumulator #(
  parameter int          N                = 8,
  parameter int          DATA_WIDTH       = 32,
  parameter int          MAX_CHAINS       = 4,
  parameter logic [7:0]  CONFIG_ID        = 8'd2,
  parameter logic [7:0]  INITIAL_FIRMWARE = 8'h00,
  localparam int         CH_W             = $clog2(MAX_CHAINS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tracing,
  input  logic [7:0]                       configId,
  input  logic [7:0]                       configData,
  input  logic                             valid_in,
  input  logic                             bof_in,
  input  logic                             eof_in,
  input  logic [CH_W-1:0]                  chainId_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
  output logic                             valid_out,
  output logic                             bof_out,
  output logic                             eof_out,
  output logic [CH_W-1:0]                  chainId_out,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out
);

  logic [7:0]                   op_q;
  logic [N-1:0][DATA_WIDTH-1:0] acc_q [MAX_CHAINS];
  chain_state_t                 state_q [MAX_CHAINS];

  logic                         valid_q;
  logic                         bof_q;
  logic                         eof_q;
  logic [CH_W-1:0]              chain_q;
  logic [N-1:0][DATA_WIDTH-1:0] vec_q;

  acc_op_t                      cur_op_s;
  logic                         start_s;
  logic [N-1:0][DATA_WIDTH-1:0] red_s;
  logic [N-1:0][DATA_WIDTH-1:0] acc_d;

  // Decode the selected chain's op and whether this vector opens a new frame.
  always_comb begin
    cur_op_s = acc_op_t'(op_q[{chainId_in, 1'b0} +: OP_W]);
    start_s  = bof_in || (state_q[chainId_in] == ST_IDLE);
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    frame_acc_lane #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .op_i     (cur_op_s),
      .acc_i    (acc_q[chainId_in][i]),
      .din_i    (vector_in[i]),
      .result_o (red_s[i])
    );
  end

  // A frame start overwrites the accumulator rather than reducing into stale data.
  always_comb begin
    if (start_s) begin
      acc_d = vector_in;
    end else begin
      acc_d = red_s;
    end
  end

  // Op register; writes are blocked while tracing and never touch accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= INITIAL_FIRMWARE;
    end else if ((configId == CONFIG_ID) && !tracing) begin
      op_q <= configData;
    end else begin
      op_q <= op_q;
    end
  end

  // Per-chain accumulators and frame state; only the addressed chain changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        acc_q[c]   <= '0;
        state_q[c] <= ST_IDLE;
      end
    end else if (valid_in && (cur_op_s != OP_PASS)) begin
      acc_q[chainId_in]   <= acc_d;
      state_q[chainId_in] <= eof_in ? ST_IDLE : ST_ACCUM;
    end else begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        acc_q[c]   <= acc_q[c];
        state_q[c] <= state_q[c];
      end
    end
  end

  // Output stage: pass-through vectors or completed reductions; data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      bof_q   <= 1'b0;
      eof_q   <= 1'b0;
      chain_q <= '0;
      vec_q   <= '0;
    end else if (valid_in && (cur_op_s == OP_PASS)) begin
      valid_q <= 1'b1;
      bof_q   <= bof_in;
      eof_q   <= eof_in;
      chain_q <= chainId_in;
      vec_q   <= vector_in;
    end else if (valid_in && eof_in) begin
      valid_q <= 1'b1;
      bof_q   <= 1'b1;
      eof_q   <= 1'b1;
      chain_q <= chainId_in;
      vec_q   <= acc_d;
    end else begin
      valid_q <= 1'b0;
      bof_q   <= 1'b0;
      eof_q   <= 1'b0;
      chain_q <= chain_q;
      vec_q   <= vec_q;
    end
  end

  assign valid_out   = valid_q;
  assign bof_out     = bof_q;
  assign eof_out     = eof_q;
  assign chainId_out = chain_q;
  assign vector_out  = vec_q;

endmodule

// File: tb/tb_frame_accumulator.sv
// Directed bench for frame_accumulator with hand-computed expected results.
module tb_frame_accumulator;

  localparam int N  = 8;
  localparam int DW = 32;

  logic                 clk;
  logic                 rst_n;
  logic                 tracing;
  logic [7:0]           configId;
  logic [7:0]           configData;
  logic                 valid_in;
  logic                 bof_in;
  logic                 eof_in;
  logic [1:0]           chainId_in;
  logic [N-1:0][DW-1:0] vector_in;
  logic                 valid_out;
  logic                 bof_out;
  logic                 eof_out;
  logic [1:0]           chainId_out;
  logic [N-1:0][DW-1:0] vector_out;

  int total;
  int bad;

  frame_accumulator #(
    .N          (N),
    .DATA_WIDTH (DW),
    .MAX_CHAINS (4),
    .CONFIG_ID  (8'd2),
    .INITIAL_FIRMWARE (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tracing     (tracing),
    .configId    (configId),
    .configData  (configData),
    .valid_in    (valid_in),
    .bof_in      (bof_in),
    .eof_in      (eof_in),
    .chainId_in  (chainId_in),
    .vector_in   (vector_in),
    .valid_out   (valid_out),
    .bof_out     (bof_out),
    .eof_out     (eof_out),
    .chainId_out (chainId_out),
    .vector_out  (vector_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0][DW-1:0] rep(input logic [DW-1:0] v);
    logic [N-1:0][DW-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v;
    return r;
  endfunction

  task automatic step(input logic [1:0] ch, input logic b, input logic e, input logic [N-1:0][DW-1:0] v);
    chainId_in = ch;
    bof_in     = b;
    eof_in     = e;
    vector_in  = v;
    valid_in   = 1'b1;
    @(posedge clk);
    #1;
    valid_in   = 1'b0;
    bof_in     = 1'b0;
    eof_in     = 1'b0;
    configId   = 8'd0;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic trace, input logic [7:0] data);
    tracing    = trace;
    configId   = 8'd2;
    configData = data;
    @(posedge clk);
    #1;
    configId   = 8'd0;
    tracing    = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic b, input logic e,
                         input logic [1:0] ch, input logic [N-1:0][DW-1:0] vec);
    check_val({tag, ".valid"}, 256'(valid_out), 256'(v));
    if (v) begin
      check_val({tag, ".bof"},   256'(bof_out),     256'(b));
      check_val({tag, ".eof"},   256'(eof_out),     256'(e));
      check_val({tag, ".chain"}, 256'(chainId_out), 256'(ch));
      check_val({tag, ".vec"},   256'(vector_out),  256'(vec));
    end
  endtask

  initial begin
    logic [N-1:0][DW-1:0] ramp;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    tracing    = 1'b0;
    configId   = 8'd0;
    configData = 8'd0;
    valid_in   = 1'b0;
    bof_in     = 1'b0;
    eof_in     = 1'b0;
    chainId_in = 2'd0;
    vector_in  = '0;
    for (int i = 0; i < N; i++) ramp[i] = 32'(i * 17 + 1);

    repeat (2) @(posedge clk);
    #1;
    check_val("rst.valid", 256'(valid_out), 256'(0));
    check_val("rst.bof",   256'(bof_out),   256'(0));
    check_val("rst.eof",   256'(eof_out),   256'(0));
    check_val("rst.chain", 256'(chainId_out), 256'(0));
    check_val("rst.vec",   256'(vector_out), 256'(0));
    rst_n = 1'b1;
    idle();

    // PASS on chain 0 with the reset op register
    step(2'd0, 1'b1, 1'b0, rep(32'd5));
    chk_out("pass", 1'b1, 1'b1, 1'b0, 2'd0, rep(32'd5));
    step(2'd3, 1'b0, 1'b1, ramp);
    chk_out("pass_ramp", 1'b1, 1'b0, 1'b1, 2'd3, ramp);

    // SUM on chain 1
    cfg(1'b0, 8'h04);
    step(2'd1, 1'b1, 1'b0, rep(32'd3));
    chk_out("sum0", 1'b0, 1'b0, 1'b0, 2'd0, '0);
    step(2'd1, 1'b0, 1'b0, rep(32'd3));
    chk_out("sum1", 1'b0, 1'b0, 1'b0, 2'd0, '0);
    step(2'd1, 1'b0, 1'b1, rep(32'd3));
    chk_out("sum2", 1'b1, 1'b1, 1'b1, 2'd1, rep(32'd9));

    // Interleaved signed MAX (chain 1) and MIN (chain 2)
    cfg(1'b0, 8'h38);
    step(2'd1, 1'b1, 1'b0, rep(32'hFFFF_FFFC));
    chk_out("max0", 1'b0, 1'b0, 1'b0, 2'd0, '0);
    step(2'd2, 1'b1, 1'b0, rep(32'hFFFF_FFFC));
    chk_out("min0", 1'b0, 1'b0, 1'b0, 2'd0, '0);
    step(2'd1, 1'b0, 1'b1, rep(32'd7));
    chk_out("max1", 1'b1, 1'b1, 1'b1, 2'd1, rep(32'd7));
    step(2'd2, 1'b0, 1'b1, rep(32'd7));
    chk_out("min1", 1'b1, 1'b1, 1'b1, 2'd2, rep(32'hFFFF_FFFC));
    idle();
    check_val("hold.valid", 256'(valid_out), 256'(0));
    check_val("hold.vec",   256'(vector_out), 256'(rep(32'hFFFF_FFFC)));

    // SUM wraps modulo 2^32
    cfg(1'b0, 8'h04);
    step(2'd1, 1'b1, 1'b0, rep(32'hFFFF_FFFF));
    step(2'd1, 1'b0, 1'b1, rep(32'd2));
    chk_out("wrap", 1'b1, 1'b1, 1'b1, 2'd1, rep(32'd1));

    // bof while accumulating drops the open frame
    step(2'd1, 1'b1, 1'b0, rep(32'd4));
    step(2'd1, 1'b1, 1'b1, rep(32'd6));
    chk_out("rebof", 1'b1, 1'b1, 1'b1, 2'd1, rep(32'd6));

    // Asynchronous reset mid-frame
    step(2'd1, 1'b1, 1'b0, rep(32'd5));
    step(2'd1, 1'b0, 1'b0, rep(32'd5));
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst.valid", 256'(valid_out), 256'(0));
    check_val("arst.vec",   256'(vector_out), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2'd1, 1'b0, 1'b0, rep(32'd7));
    chk_out("arst_pass", 1'b1, 1'b0, 1'b0, 2'd1, rep(32'd7));
    cfg(1'b0, 8'h04);
    step(2'd1, 1'b0, 1'b0, rep(32'd1));
    chk_out("arst_f0", 1'b0, 1'b0, 1'b0, 2'd0, '0);
    step(2'd1, 1'b0, 1'b1, rep(32'd2));
    chk_out("arst_f1", 1'b1, 1'b1, 1'b1, 2'd1, rep(32'd3));

    // Config gating while tracing
    cfg(1'b1, 8'hFF);
    step(2'd0, 1'b0, 1'b0, rep(32'd8));
    chk_out("gated", 1'b1, 1'b0, 1'b0, 2'd0, rep(32'd8));
    cfg(1'b0, 8'hFF);
    step(2'd0, 1'b1, 1'b0, rep(32'd8));
    chk_out("min_a", 1'b0, 1'b0, 1'b0, 2'd0, '0);
    step(2'd0, 1'b0, 1'b1, rep(32'd3));
    chk_out("min_b", 1'b1, 1'b1, 1'b1, 2'd0, rep(32'd3));

    // Config write alongside an input: that input still sees the old op
    configId   = 8'd2;
    configData = 8'h00;
    step(2'd0, 1'b1, 1'b0, rep(32'd9));
    chk_out("cfg_same", 1'b0, 1'b0, 1'b0, 2'd0, '0);
    step(2'd0, 1'b0, 1'b0, rep(32'd2));
    chk_out("cfg_next", 1'b1, 1'b0, 1'b0, 2'd0, rep(32'd2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
